shift_sequencer: RTL
====================

Name: shift_sequencer

Overview:
Controller that shares the single combinational 32-bit barrel shifter (`SHIFT32`) between two requesters, for example the ALU path and the address/immediate path. It arbitrates round-robin, captures the winner's operands and drives the shifter's D/S/LnR inputs. It registers the shifter output and returns the result with a DONE pulse. Under `SHIFT_ROTATE_EN` it also sequences two shifter passes to build rotates.

Parameters:
RR_INIT, 1, requester index treated as last-served at reset; with 1, requester 0 wins the first tie.
DONE_HOLD, 0, 0 = RESULT valid only in the DONE cycle; 1 = RESULT held until the next DONE.

Ports:
CLK  input  1  clock; all state updates on the rising edge
RST  input  1  reset, asynchronous, active-low
REQ0  input  1  requester 0 request; held high until GNT0
OP0  input  2  requester 0 opcode: 00 SRL, 01 SLL, 10 ROR, 11 ROL
DATA0  input  32  requester 0 operand
AMT0  input  32  requester 0 shift amount
REQ1, OP1, DATA1, AMT1  input  1/2/32/32  requester 1, same meaning as requester 0
GNT0, GNT1  output  1  one-cycle grant pulse; operands are captured in this cycle
DONE0, DONE1  output  1  one-cycle completion pulse to the granted requester
RESULT  output  32  shift result, valid with DONEx
BUSY  output  1  high whenever the state is not IDLE
SH_D  output  32  to shifter D
SH_S  output  32  to shifter S
SH_LNR  output  1  to shifter LnR; 1 = left, 0 = right
SH_Y  input  32  from shifter Y (combinational)

Behaviour:
- Reset (RST=0, asynchronous):
  - state IDLE; all GNT/DONE, BUSY, RESULT, SH_D, SH_S and SH_LNR are 0.
  - RR pointer = RR_INIT.
  - An operation in flight is aborted; no DONE is issued for it.
- States: IDLE, PASS1, PASS2, DONE.
- IDLE:
  - If any REQ is high, grant one (GNTx=1 for that cycle), latch OP, DATA, AMT and the owner index, then go to PASS1.
  - If both REQ are high, grant the requester that was not last served, then update the pointer.
  - A single requester is granted regardless of the pointer.
- PASS1:
  - SH_D = DATA, SH_S = AMT; SH_LNR = OP[0] for shifts.
  - For ROR, SH_LNR=0 and SH_S={27'b0, AMT[4:0]}; for ROL, SH_LNR=1 and SH_S={27'b0, AMT[4:0]}.
  - At the clock edge, ACC <= SH_Y.
  - Shift ops go to DONE. Rotate ops go to PASS2, or straight to DONE if AMT[4:0]==0, in which case ACC=DATA.
- PASS2 (rotate only):
  - SH_D = DATA, SH_LNR = ~PASS1 direction, SH_S = 32 - AMT[4:0] (range 1..31).
  - At the clock edge, ACC <= ACC | SH_Y; go to DONE.
- DONE:
  - RESULT = ACC and DONEx=1 for the owner; go to IDLE.
  - No grant is issued in this cycle; REQ seen here is granted on the next IDLE cycle.
- Latency from GNT cycle t: shift DONE at t+2; rotate DONE at t+3, or t+2 when AMT[4:0]==0.
- Throughput: one grant per 3 cycles for shifts.
- Amount handling:
  - Shifts pass the full 32-bit AMT; the shifter returns 0 when AMT>=32.
  - Rotates use AMT mod 32.
- REQ high while BUSY: no grant; the requester keeps waiting. REQ dropped before GNT: the request is withdrawn.
- SH_* outputs are 0 in IDLE and DONE.

Optional Feature:
SHIFT_ROTATE_EN.
- Defined: ROR/ROL are supported and PASS2 exists.
- Undefined: OP[1] is ignored and every op is a shift with direction OP[0]; the PASS2 state is not compiled, so latency is always t+2.

Decomposition:
- Shared definitions include: opcode constants `SHOP_SRL`/`SHOP_SLL`/`SHOP_ROR`/`SHOP_ROL` and state encodings `SHSEQ_IDLE`/`PASS1`/`PASS2`/`DONE`.
- One sub-module, rr_arb2: 2-input round-robin arbiter with pointer register, on CLK/RST.
- The shifter itself stays external, instantiated beside this block.

Test Plan:
- Reset behaviour: RST low mid-PASS1 -> next cycle state IDLE, BUSY=0, DONE0=DONE1=0, RESULT=0.
- Single SLL: REQ0, OP0=01, DATA0=0x0000_00F0, AMT0=4 -> GNT0 at t, DONE0 at t+2, RESULT=0x0000_0F00.
- Large SRL: REQ1, OP1=00, DATA1=0xFFFF_FFFF, AMT1=40 -> DONE1 at t+2, RESULT=0x0000_0000.
- Tie after reset: REQ0 and REQ1 both high -> GNT0 first; GNT1 in the first IDLE cycle after DONE0; a further tie then grants requester 0.
- ROR with SHIFT_ROTATE_EN: DATA=0x8000_0001, AMT=4 -> PASS1 right 4, PASS2 left 28, DONE at t+3, RESULT=0x1800_0000.
- ROL AMT=32, and ROR without the macro:
  - With the macro, ROL AMT=32 -> RESULT=DATA at t+2.
  - Without the macro, OP=10 with DATA=0x8000_0001, AMT=4 -> executes SRL, RESULT=0x0800_0000.

Source files
------------

// File: rtl/shift_sequencer_pkg.sv
// Shared opcode, state and helper definitions for the shift sequencer.
// Rotate support is enabled with the SHIFT_ROTATE_EN macro.
package shift_sequencer_pkg;

    localparam logic [1:0] SHOP_SRL = 2'b00;
    localparam logic [1:0] SHOP_SLL = 2'b01;
    localparam logic [1:0] SHOP_ROR = 2'b10;
    localparam logic [1:0] SHOP_ROL = 2'b11;

    typedef enum logic [1:0] {
        SHSEQ_IDLE  = 2'd0,
        SHSEQ_PASS1 = 2'd1,
        SHSEQ_PASS2 = 2'd2,
        SHSEQ_DONE  = 2'd3
    } shseq_state_e;

    // Second-pass amount for a rotate: the complementary shift, 1..31.
    function automatic logic [31:0] rot_comp(input logic [4:0] amt);
        return 32'd32 - {27'b0, amt};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer records the last requester served.
module rr_arb2
    import shift_sequencer_pkg::*;
#(
    parameter bit RR_INIT = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic last_q;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            last_q <= RR_INIT;
        end else if (gnt_o[0]) begin
            last_q <= 1'b0;
        end else if (gnt_o[1]) begin
            last_q <= 1'b1;
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Shares one external 32-bit barrel shifter between two requesters.
// Define SHIFT_ROTATE_EN to build rotates from two shifter passes.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter bit RR_INIT   = 1'b1,
    parameter bit DONE_HOLD = 1'b0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ0,
    input  logic [1:0]  OP0,
    input  logic [31:0] DATA0,
    input  logic [31:0] AMT0,
    input  logic        REQ1,
    input  logic [1:0]  OP1,
    input  logic [31:0] DATA1,
    input  logic [31:0] AMT1,
    output logic        GNT0,
    output logic        GNT1,
    output logic        DONE0,
    output logic        DONE1,
    output logic [31:0] RESULT,
    output logic        BUSY,
    output logic [31:0] SH_D,
    output logic [31:0] SH_S,
    output logic        SH_LNR,
    input  logic [31:0] SH_Y
);

    shseq_state_e state_q;
    logic         owner_q;
    logic [31:0]  sh_d_q;
    logic [31:0]  sh_s_q;
    logic         sh_lnr_q;
    logic [31:0]  result_q;
    logic         done0_q;
    logic         done1_q;
`ifdef SHIFT_ROTATE_EN
    logic         rot_q;
    logic [31:0]  acc_q;
`else
    logic         unused_op_hi;
    assign unused_op_hi = OP0[1] ^ OP1[1];
`endif

    logic [1:0]   gnt;
    logic [1:0]   sel_op;
    logic [31:0]  sel_data;
    logic [31:0]  sel_amt;
    logic         finish_d;
    logic [31:0]  result_d;

    rr_arb2 #(.RR_INIT(RR_INIT)) u_arb (
        .CLK   (CLK),
        .RST   (RST),
        .en_i  (state_q == SHSEQ_IDLE),
        .req_i ({REQ1, REQ0}),
        .gnt_o (gnt)
    );

    assign sel_op   = gnt[1] ? OP1   : OP0;
    assign sel_data = gnt[1] ? DATA1 : DATA0;
    assign sel_amt  = gnt[1] ? AMT1  : AMT0;

    // Decide whether the current pass is the last one and what it produces.
    always_comb begin
        finish_d = 1'b0;
        result_d = SH_Y;
        case (state_q)
`ifdef SHIFT_ROTATE_EN
            SHSEQ_PASS1: begin
                finish_d = !(rot_q && (sh_s_q[4:0] != 5'd0));
                result_d = rot_q ? sh_d_q : SH_Y;
            end
            SHSEQ_PASS2: begin
                finish_d = 1'b1;
                result_d = acc_q | SH_Y;
            end
`else
            SHSEQ_PASS1: begin
                finish_d = 1'b1;
                result_d = SH_Y;
            end
`endif
            default: begin
                finish_d = 1'b0;
                result_d = SH_Y;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= SHSEQ_IDLE;
            owner_q  <= 1'b0;
            sh_d_q   <= 32'd0;
            sh_s_q   <= 32'd0;
            sh_lnr_q <= 1'b0;
            result_q <= 32'd0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
`ifdef SHIFT_ROTATE_EN
            rot_q    <= 1'b0;
            acc_q    <= 32'd0;
`endif
        end else if (finish_d) begin
            result_q <= result_d;
            done0_q  <= ~owner_q;
            done1_q  <= owner_q;
            sh_d_q   <= 32'd0;
            sh_s_q   <= 32'd0;
            sh_lnr_q <= 1'b0;
            state_q  <= SHSEQ_DONE;
        end else begin
            case (state_q)
                SHSEQ_IDLE: begin
                    if (|gnt) begin
                        owner_q  <= gnt[1];
                        sh_d_q   <= sel_data;
                        sh_lnr_q <= sel_op[0];
`ifdef SHIFT_ROTATE_EN
                        rot_q    <= sel_op[1];
                        sh_s_q   <= sel_op[1] ? {27'b0, sel_amt[4:0]} : sel_amt;
`else
                        sh_s_q   <= sel_amt;
`endif
                        state_q  <= SHSEQ_PASS1;
                    end
                end
`ifdef SHIFT_ROTATE_EN
                // Non-final PASS1 only happens for a rotate with a nonzero amount.
                SHSEQ_PASS1: begin
                    acc_q    <= SH_Y;
                    sh_s_q   <= rot_comp(sh_s_q[4:0]);
                    sh_lnr_q <= ~sh_lnr_q;
                    state_q  <= SHSEQ_PASS2;
                end
`endif
                SHSEQ_DONE: begin
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    if (!DONE_HOLD) begin
                        result_q <= 32'd0;
                    end
                    state_q <= SHSEQ_IDLE;
                end
                default: state_q <= SHSEQ_IDLE;
            endcase
        end
    end

    assign GNT0   = gnt[0];
    assign GNT1   = gnt[1];
    assign DONE0  = done0_q;
    assign DONE1  = done1_q;
    assign RESULT = result_q;
    assign BUSY   = (state_q != SHSEQ_IDLE);
    assign SH_D   = sh_d_q;
    assign SH_S   = sh_s_q;
    assign SH_LNR = sh_lnr_q;

endmodule
